// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register-transaction sequencer:
//   - byte-engine command bit constants (START/WRITE/READ/STOP/ACK)
//   - sequencer FSM state encoding
//   - byte-select codes used by the sequence ROM
//   - sequence lengths for write (3 steps) and read (4 steps)
// No ports; imported by the interface, the ROM and the top.
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam logic [4:0] CMD_START = 5'b00001;
  localparam logic [4:0] CMD_WRITE = 5'b00010;
  localparam logic [4:0] CMD_READ  = 5'b00100;
  localparam logic [4:0] CMD_STOP  = 5'b01000;
  // ACK=1 tells the engine the master answers the read byte with NACK.
  localparam logic [4:0] CMD_ACK   = 5'b10000;

  localparam int SEQ_LEN_WR = 3;
  localparam int SEQ_LEN_RD = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    SEL_DEV_W = 3'd0,  // {DEV_ADDR, 0}
    SEL_ADDR  = 3'd1,  // register address
    SEL_WDATA = 3'd2,  // write data
    SEL_DEV_R = 3'd3,  // {DEV_ADDR, 1}
    SEL_ZERO  = 3'd4   // 0x00
  } sel_t;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_ctrl_if
// Bundles the request/response channel and the byte-engine command channel of
// the register sequencer.
//   slave  : view of the sequencer itself
//   master : view of whoever drives requests and models the byte engine
// Handshakes:
//   request  - transfer happens on a clock edge where req_vld && req_rdy;
//              req_rdy is high only while the sequencer is idle, and req_*
//              are captured on that edge.
//   response - rsp_vld is a single-cycle pulse, no ready; rsp_rdata/rsp_err
//              are meaningful only while rsp_vld is high.
//   command  - cmd_vld is a single-cycle issue strobe; cmd/wr_data stay stable
//              until the engine's done pulse for that command.
// dbg_state mirrors the sequencer FSM state for observation.
// -----------------------------------------------------------------------------
interface i2c_reg_ctrl_if;
  import i2c_pkg::*;

  logic       req_vld;
  logic       req_rdy;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_vld;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [4:0] cmd;
  logic [7:0] wr_data;
  logic       cmd_vld;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_data_vld;
  logic       rev_ack;
  state_t     dbg_state;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, done, rd_data, rd_data_vld, rev_ack,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err, cmd, wr_data, cmd_vld, dbg_state
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, done, rd_data, rd_data_vld, rev_ack,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err, cmd, wr_data, cmd_vld, dbg_state
  );

endinterface

// File: rtl/i2c_seq_rom.sv
// -----------------------------------------------------------------------------
// i2c_seq_rom
// Combinational map from (transfer direction, step) to the engine command,
// the byte to send and a last-step flag.
// Ports:
//   wr   in  1  1 = write sequence, 0 = read sequence
//   step in  2  step index
//   cmd  out 5  engine command bits
//   sel  out    byte select code
//   last out 1  this step ends the sequence
// -----------------------------------------------------------------------------
module i2c_seq_rom
  import i2c_pkg::*;
(
  input  logic       wr,
  input  logic [1:0] step,
  output logic [4:0] cmd,
  output sel_t       sel,
  output logic       last
);

  always_comb begin
    cmd  = '0;
    sel  = SEL_ZERO;
    last = (int'(step) == ((wr ? SEQ_LEN_WR : SEQ_LEN_RD) - 1));
    unique case (step)
      2'd0: begin cmd = CMD_START | CMD_WRITE; sel = SEL_DEV_W; end
      2'd1: begin cmd = CMD_WRITE;             sel = SEL_ADDR;  end
      2'd2: begin
        if (wr) begin
          cmd = CMD_WRITE | CMD_STOP;
          sel = SEL_WDATA;
        end else begin
          // repeated START with the read address
          cmd = CMD_START | CMD_WRITE;
          sel = SEL_DEV_R;
        end
      end
      default: begin
        // read: single byte, master NACKs it and stops; write never gets here
        cmd = wr ? 5'd0 : (CMD_READ | CMD_STOP | CMD_ACK);
        sel = SEL_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_reg_ctrl
// Breaks a single-register write/read request into I2C byte-engine commands,
// waits for each done, checks the slave ACK after every written byte, forces
// a STOP on an early NACK and returns one response per request.
// Ports:
//   sys_clk  in  clock
//   sys_rst  in  synchronous active-high reset
//   bus      i2c_reg_ctrl_if.slave (request, response, engine command channel)
// Parameters: DEV_ADDR (7-bit slave address), MAX_RETRY (address retries).
// Build option: define I2C_REG_CTRL_RETRY_EN to retry an address-byte NACK
// up to MAX_RETRY times before reporting an error.
// -----------------------------------------------------------------------------
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'b1010_100,
  parameter int         MAX_RETRY = 2
) (
  input logic           sys_clk,
  input logic           sys_rst,
  i2c_reg_ctrl_if.slave bus
);

  state_t     state, state_next;
  logic [1:0] step, step_next;
  logic       wr_q;
  logic [7:0] addr_q, wdata_q;
  logic [4:0] cmd_q;
  logic [7:0] data_q;
  logic       last_q;
  logic       rec_busy;   // recovery command already strobed
  logic [7:0] rdata_q;
  logic       err_q;
  logic       load_seq, load_rec, set_err;

  logic       idle;
  logic       rom_wr;
  logic [4:0] rom_cmd;
  sel_t       rom_sel;
  logic       rom_last;
  logic [7:0] src_addr, src_wdata, seq_byte;

`ifdef I2C_REG_CTRL_RETRY_EN
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q;
  logic          retry_inc;
`endif

  assign idle = (state == ST_IDLE);

  // While idle the ROM looks at the live request so the first command can be
  // loaded on the acceptance edge.
  assign rom_wr    = idle ? bus.req_wr    : wr_q;
  assign src_addr  = idle ? bus.req_addr  : addr_q;
  assign src_wdata = idle ? bus.req_wdata : wdata_q;

  i2c_seq_rom u_rom (
    .wr   (rom_wr),
    .step (step_next),
    .cmd  (rom_cmd),
    .sel  (rom_sel),
    .last (rom_last)
  );

  always_comb begin
    seq_byte = 8'h00;
    unique case (rom_sel)
      SEL_DEV_W: seq_byte = {DEV_ADDR, 1'b0};
      SEL_ADDR:  seq_byte = src_addr;
      SEL_WDATA: seq_byte = src_wdata;
      SEL_DEV_R: seq_byte = {DEV_ADDR, 1'b1};
      default:   seq_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    load_seq   = 1'b0;
    load_rec   = 1'b0;
    set_err    = 1'b0;
`ifdef I2C_REG_CTRL_RETRY_EN
    retry_inc  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (bus.req_vld) begin
          state_next = ST_ISSUE;
          step_next  = 2'd0;
          load_seq   = 1'b1;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.done) begin
          if (last_q) begin
            // a NACK here already went out with STOP, so no recovery needed
            state_next = ST_RESP;
            set_err    = cmd_q[1] & bus.rev_ack;
          end else if (cmd_q[1] && bus.rev_ack) begin
            state_next = ST_RECOVER;
            load_rec   = 1'b1;
          end else begin
            state_next = ST_ISSUE;
            step_next  = step + 2'd1;
            load_seq   = 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        if (rec_busy && bus.done) begin
          state_next = ST_RESP;
          set_err    = 1'b1;
`ifdef I2C_REG_CTRL_RETRY_EN
          // step still names the byte that was NACKed; only step0 retries
          if (step == 2'd0 && int'(retry_q) < MAX_RETRY) begin
            state_next = ST_ISSUE;
            set_err    = 1'b0;
            load_seq   = 1'b1;
            retry_inc  = 1'b1;
          end
`endif
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      step     <= 2'd0;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      cmd_q    <= 5'd0;
      data_q   <= 8'h00;
      last_q   <= 1'b0;
      rec_busy <= 1'b0;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
`ifdef I2C_REG_CTRL_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state    <= state_next;
      step     <= step_next;
      rec_busy <= (state == ST_RECOVER);
      if (idle && bus.req_vld) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= 8'h00;
        err_q   <= 1'b0;
`ifdef I2C_REG_CTRL_RETRY_EN
        retry_q <= '0;
`endif
      end
`ifdef I2C_REG_CTRL_RETRY_EN
      if (retry_inc) retry_q <= retry_q + 1'b1;
`endif
      if (load_seq) begin
        cmd_q  <= rom_cmd;
        data_q <= seq_byte;
        last_q <= rom_last;
      end
      if (load_rec) begin
        // dummy 0xFF byte with STOP releases the bus after a NACK
        cmd_q  <= CMD_WRITE | CMD_STOP;
        data_q <= 8'hFF;
        last_q <= 1'b0;
      end
      if (bus.rd_data_vld && !idle) rdata_q <= bus.rd_data;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign bus.req_rdy   = idle;
  assign bus.cmd_vld   = (state == ST_ISSUE) || (state == ST_RECOVER && !rec_busy);
  assign bus.cmd       = cmd_q;
  assign bus.wr_data   = data_q;
  assign bus.rsp_vld   = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-transaction sequencer that sits directly upstream of the I2C byte engine (`i2c`). It accepts a single-register write or read request and breaks it into the engine's byte commands (START/WRITE/READ/STOP/ACK). Between commands it waits for the engine's `done`, checks the slave ACK after every written byte, and returns one response per request. It is the block the ADC/DAC control logic talks to instead of driving the byte engine directly.

## Interface
Parameters:
- `DEV_ADDR`, default 7'b1010_100: 7-bit slave address.
- `MAX_RETRY`, default 2: retry count, used only with the macro below.

Ports:
- `sys_clk`  in  1  system clock; single clock domain.
- `sys_rst`  in  1  reset: **synchronous and active-high**.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  high only in IDLE.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  register address.
- `req_wdata`  in  8  write data.
- `rsp_vld`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  8  read data; valid with `rsp_vld`.
- `rsp_err`  out  1  NACK abort; valid with `rsp_vld`.
- `cmd`  out  5  to engine: bit0 START, bit1 WRITE, bit2 READ, bit3 STOP, bit4 ACK (ACK=1 means master sends NACK).
- `wr_data`  out  8  to engine: byte to send.
- `cmd_vld`  out  1  to engine: one-cycle issue strobe.
- `done`  in  1  from engine: command-complete pulse.
- `rd_data`  in  8  from engine: received byte.
- `rd_data_vld`  in  1  from engine: `rd_data` valid pulse.
- `rev_ack`  in  1  from engine: sampled slave ACK (0 = ACK).

## Operation
- States:
  - IDLE: `req_rdy`=1.
  - ISSUE: `cmd_vld`=1 for exactly one cycle.
  - WAIT: wait for `done`.
  - RECOVER: issue the recovery command, then wait for `done`.
  - RESP: `rsp_vld`=1 for one cycle, then return to IDLE.
- A request is accepted on `req_vld && req_rdy`; `req_addr`, `req_wdata` and `req_wr` are latched at acceptance.
- A 2-bit step counter selects the command for each step:
  - Write sequence: step0 `cmd`=0x03, data {DEV_ADDR,0}; step1 0x02, `req_addr`; step2 0x0A, `req_wdata`.
  - Read sequence: step0 0x03, {DEV_ADDR,0}; step1 0x02, `req_addr`; step2 0x03, {DEV_ADDR,1} (repeated START); step3 0x1C, data 0x00.
- On `done` in WAIT:
  - Last step: go to RESP.
  - Write-type step with `rev_ack`=1: go to RECOVER.
  - Otherwise: increment the step counter and go to ISSUE.
- RECOVER issues `cmd`=0x0A with data 0xFF to force a STOP, waits for `done`, then goes to RESP with `rsp_err`=1.
- NACK on the final write step (step2 of a write, whose command already carries STOP): go straight to RESP with `rsp_err`=1.
- `rsp_rdata` is captured on any `rd_data_vld`; it is 0x00 for writes.
- `req_vld` while busy is ignored; there is no queue.

## Timing
- Reset values: state IDLE, `req_rdy` 1, `cmd_vld` 0, `cmd` 0, `wr_data` 0, `rsp_vld` 0, `rsp_rdata` 0, `rsp_err` 0, step 0.
- `cmd_vld` rises the cycle after acceptance.
- Each subsequent `cmd_vld` rises the cycle after the previous `done`.
- `cmd` and `wr_data` are held stable from `cmd_vld` until the matching `done`. The engine reads `cmd` live during its ACK phase.
- `rsp_vld` rises the cycle after the final `done`; there is no backpressure.
- `done` outside WAIT/RECOVER is ignored.
- `rd_data_vld` and `done` in the same cycle: capture the data, then advance.
- Reset mid-transaction returns to IDLE next cycle with all outputs at reset values and no response.
  - The engine keeps its own state; the system resets both blocks together.

## Configuration
- `I2C_REG_CTRL_RETRY_EN` defined:
  - A NACK on step0 (address byte) runs RECOVER, then restarts from step0, up to `MAX_RETRY` times.
  - `rsp_err`=1 only after the final attempt also NACKs.
  - A NACK on any later step is never retried.
- Macro undefined: no retry counter is compiled in; the first NACK ends the request with `rsp_err`=1.

## Structure
- Shared package `i2c_pkg`:
  - Command bit constants (START/WRITE/READ/STOP/ACK).
  - FSM state encoding.
  - Sequence lengths: write 3, read 4.
- Sub-module `i2c_seq_rom`: combinational map from (`req_wr`, step) to `cmd`, byte select and last flag.
- FSM, latches and the retry counter stay in `i2c_reg_ctrl`.

## Test plan
- Write request, addr 0x10, data 0xA5, behavioural engine model always ACKs:
  - Commands in order: (0x03, 0xA8), (0x02, 0x10), (0x0A, 0xA5).
  - One `rsp_vld` with `rsp_err`=0.
- Read request, addr 0x20, model returns 0x3C:
  - Commands in order: (0x03, 0xA8), (0x02, 0x20), (0x03, 0xA9), (0x1C, 0x00).
  - `rsp_rdata`=0x3C, `rsp_err`=0.
- `rev_ack`=1 at step0 `done`, macro off:
  - Next command is (0x0A, 0xFF); no step1 is issued.
  - Response has `rsp_err`=1.
- `rev_ack`=1 at step0 `done` on the first attempt only, macro on with `MAX_RETRY`=2:
  - Recovery command, then (0x03, 0xA8) is reissued.
  - Completes with `rsp_err`=0.
- Assert `sys_rst` during step1 WAIT:
  - All outputs return to reset values next cycle; no `rsp_vld`.
  - A new request afterwards starts at step0.
- `req_vld` held high during a transaction: exactly one response per accepted request, and `req_rdy`=0 until after RESP.
